// File: rtl/edge_conv5x5.sv
// 5x5 signed-kernel convolution over a gray image held in an external synchronous memory.
// Borders are zero padded; each result is clamped to 0..255 and emitted in row-major order.
module edge_conv5x5 #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fc_valid,
    input  logic [7:0]        fc,
    output logic              img_rd,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_data,
    output logic [7:0]        out_pixel,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, CONV, OUT, FIN} state_t;

    state_t             state;
    logic signed [7:0]  coef [25];
    logic [4:0]         idx;
    logic [4:0]         t;
    logic [2:0]         tr;
    logic [2:0]         tc;
    logic [RW-1:0]      row;
    logic [CW-1:0]      col;
    logic signed [21:0] acc;
    logic               pend_v;
    logic [4:0]         pend_t;
    logic [ADDR_W-1:0]  addr_q;

    int                 src_r;
    int                 src_c;
    logic               in_b;
    logic [ADDR_W-1:0]  src_addr;
    logic signed [16:0] prod;
    logic [7:0]         clamped;

    // Source pixel of the current tap, its bounds test, and the product for the tap issued last cycle.
    always_comb begin
        src_r    = int'(row) + int'(tr) - 2;
        src_c    = int'(col) + int'(tc) - 2;
        in_b     = (state == CONV) && (t <= 5'd24) &&
                   (src_r >= 0) && (src_r < IMG_H) &&
                   (src_c >= 0) && (src_c < IMG_W);
        src_addr = ADDR_W'(src_r * IMG_W + src_c);
        prod     = coef[pend_t] * $signed({1'b0, img_data});
        if (acc < 22'sd0)
            clamped = 8'd0;
        else if (acc > 22'sd255)
            clamped = 8'd255;
        else
            clamped = acc[7:0];
    end

    assign img_rd   = in_b;
    assign img_addr = in_b ? src_addr : addr_q;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            for (int i = 0; i < 25; i++)
                coef[i] <= '0;
            idx       <= '0;
            t         <= '0;
            tr        <= '0;
            tc        <= '0;
            row       <= '0;
            col       <= '0;
            acc       <= '0;
            pend_v    <= 1'b0;
            pend_t    <= '0;
            addr_q    <= '0;
            out_pixel <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            if (in_b)
                addr_q <= src_addr;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (fc_valid) begin
                        coef[idx] <= fc;
                        idx       <= idx + 5'd1;
                        if (idx == 5'd24) begin
                            state <= CONV;
                            row   <= '0;
                            col   <= '0;
                            t     <= '0;
                            tr    <= '0;
                            tc    <= '0;
                        end
                    end
                end
                CONV: begin
                    // The memory answers one cycle late, so the tap issued now is summed next edge.
                    pend_v <= in_b;
                    pend_t <= t;
                    if (t == 5'd0)
                        acc <= '0;
                    else if (pend_v)
                        acc <= acc + {{5{prod[16]}}, prod};
                    if (t == 5'd25) begin
                        state <= OUT;
                    end else begin
                        t <= t + 5'd1;
                        if (tc == 3'd4) begin
                            tc <= '0;
                            tr <= tr + 3'd1;
                        end else begin
                            tc <= tc + 3'd1;
                        end
                    end
                end
                OUT: begin
                    out_pixel <= clamped;
                    out_valid <= 1'b1;
                    t         <= '0;
                    tr        <= '0;
                    tc        <= '0;
                    if (col == CW'(IMG_W - 1)) begin
                        col <= '0;
                        row <= row + RW'(1);
                        if (row == RW'(IMG_H - 1))
                            state <= FIN;
                        else
                            state <= CONV;
                    end else begin
                        col   <= col + CW'(1);
                        state <= CONV;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_conv5x5.sv
// Directed bench for edge_conv5x5 on an 8x8 image: flat, impulse, gradient, identity and mid-frame reset frames.
module tb_edge_conv5x5;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int AW   = 6;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          fc_valid;
    logic [7:0]    fc;
    logic          img_rd;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_data = 8'h00;
    logic [7:0]    out_pixel;
    logic          out_valid;
    logic          busy;
    logic          done;

    edge_conv5x5 #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fc_valid  (fc_valid),
        .fc        (fc),
        .img_rd    (img_rd),
        .img_addr  (img_addr),
        .img_data  (img_data),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [7:0]        mem  [NPIX];
    logic signed [7:0] kern [25];

    always @(posedge clk) if (img_rd) img_data <= mem[img_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_out, n_done, first_rd_cyc, first_rd_addr, done_cyc, unstable, conv_cyc;
    logic       done_busy;
    logic [7:0] prev_pix;
    logic [7:0] got [NPIX];
    int         valid_cyc [NPIX];

    // Observer sampling on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (out_valid) begin
            if (n_out < NPIX) begin
                got[n_out]       = out_pixel;
                valid_cyc[n_out] = cyc;
            end
            n_out++;
        end else if (out_pixel !== prev_pix) begin
            unstable++;
        end
        prev_pix = out_pixel;
        if (img_rd && first_rd_cyc < 0) begin
            first_rd_cyc  = cyc;
            first_rd_addr = int'(img_addr);
        end
        if (done) begin
            n_done++;
            done_busy = busy;
            done_cyc  = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_pix(input int r, input int c);
        int a = 0;
        for (int dr = 0; dr < 5; dr++)
            for (int dc = 0; dc < 5; dc++) begin
                int sr = r + dr - 2;
                int sc = c + dc - 2;
                if (sr >= 0 && sr < H && sc >= 0 && sc < W)
                    a += int'(kern[dr*5+dc]) * int'(mem[sr*W+sc]);
            end
        if (a < 0) return 8'd0;
        if (a > 255) return 8'd255;
        return 8'(a);
    endfunction

    task automatic clear_monitor();
        n_out        = 0;
        n_done       = 0;
        first_rd_cyc = -1;
        first_rd_addr = -1;
        done_cyc     = -1;
        unstable     = 0;
        done_busy    = 1'b1;
        prev_pix     = out_pixel;
        for (int i = 0; i < NPIX; i++) begin
            got[i]       = 8'h00;
            valid_cyc[i] = 0;
        end
    endtask

    task automatic apply_stimulus(input bit gap);
        clear_monitor();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            fc       = kern[k];
            fc_valid = 1'b1;
            @(negedge clk);
            if (k == 10 && gap) begin
                fc_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
        fc_valid = 1'b0;
        conv_cyc = cyc;
    endtask

    task automatic wait_done();
        for (int i = 0; i < NPIX * 27 + 200 && n_done == 0; i++)
            @(negedge clk);
        check_val("done_seen", 32'(n_done > 0), 1);
        @(negedge clk);
    endtask

    task automatic check_output(input string name);
        check_val({name, "_count"}, n_out, NPIX);
        check_val({name, "_done_once"}, n_done, 1);
        check_val({name, "_busy_at_done"}, 32'(done_busy), 0);
        check_val({name, "_stable"}, unstable, 0);
        for (int i = 0; i < NPIX; i++)
            check_val($sformatf("%s_px%0d", name, i), got[i], model_pix(i / W, i % W));
    endtask

    task automatic set_laplacian();
        for (int k = 0; k < 25; k++) kern[k] = (k == 12) ? 8'sd24 : -8'sd1;
    endtask

    task automatic set_identity();
        for (int k = 0; k < 25; k++) kern[k] = (k == 12) ? 8'sd1 : 8'sd0;
    endtask

    task automatic set_gradient_kernel();
        for (int k = 0; k < 25; k++) kern[k] = 8'sd0;
        kern[12] = 8'sd3;
        kern[7]  = -8'sd1;
        kern[14] = 8'sd1;
    endtask

    task automatic check_all_zero(input string name);
        check_val({name, "_out_pixel"}, out_pixel, 0);
        check_val({name, "_out_valid"}, out_valid, 0);
        check_val({name, "_img_rd"}, img_rd, 0);
        check_val({name, "_img_addr"}, img_addr, 0);
        check_val({name, "_busy"}, busy, 0);
        check_val({name, "_done"}, done, 0);
    endtask

    initial begin
        int bad;
        int saved;
        rst      = 1'b1;
        start    = 1'b0;
        fc_valid = 1'b0;
        fc       = 8'h00;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Flat image with Laplacian, 3-cycle coefficient gap, plus protocol timing.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd100;
        set_laplacian();
        apply_stimulus(1'b1);
        check_val("flat_busy_conv", busy, 1);
        check_val("flat_no_rd_t0", img_rd, 0);
        wait_done();
        check_output("flat");
        check_val("flat_corner", got[0], 255);
        check_val("flat_edge_0_4", got[4], 255);
        check_val("flat_1_1", got[1*W+1], 255);
        check_val("flat_inner_2_2", got[2*W+2], 0);
        check_val("flat_inner_3_3", got[3*W+3], 0);
        check_val("first_rd_tap12", first_rd_cyc - conv_cyc, 12);
        check_val("first_rd_addr", first_rd_addr, 0);
        check_val("first_valid_lat", valid_cyc[0] - conv_cyc, 27);
        bad = 0;
        for (int i = 1; i < NPIX; i++)
            if (valid_cyc[i] - valid_cyc[i-1] != 27) bad++;
        check_val("valid_spacing", bad, 0);
        check_val("done_after_last", done_cyc - valid_cyc[NPIX-1], 1);

        // Single bright pixel at (4,4).
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
        mem[4*W+4] = 8'd255;
        apply_stimulus(1'b0);
        wait_done();
        check_output("impulse");
        check_val("impulse_centre", got[4*W+4], 255);
        check_val("impulse_4_5", got[4*W+5], 0);
        check_val("impulse_4_6", got[4*W+6], 0);
        check_val("impulse_7_4", got[7*W+4], 0);

        // Gradient image with start and fc_valid noise during the convolution.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        set_gradient_kernel();
        apply_stimulus(1'b0);
        repeat (40) @(negedge clk);
        start    = 1'b1;
        fc_valid = 1'b1;
        fc       = 8'h7f;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        fc = 8'h80;
        repeat (5) @(negedge clk);
        fc_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check_output("grad");
        check_val("grad_0_0", got[0], 2);
        check_val("grad_2_0", got[2*W+0], 58);
        check_val("grad_3_5", got[3*W+5], 97);
        check_val("grad_5_7", got[5*W+7], 102);
        check_val("grad_7_1", got[7*W+1], 181);
        check_val("grad_7_6", got[7*W+6], 132);

        // Identity kernel on a random image.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
        set_identity();
        apply_stimulus(1'b0);
        wait_done();
        check_output("ident");
        bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (got[i] !== mem[i]) bad++;
        check_val("ident_equals_input", bad, 0);

        // Asynchronous reset in the middle of row 5, then a full fresh frame.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
        set_gradient_kernel();
        apply_stimulus(1'b0);
        for (int i = 0; i < NPIX * 27 && n_out < 5*W + 4; i++)
            @(negedge clk);
        check_val("rst_reached_mid", 32'(n_out >= 5*W + 4), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst   = 1'b0;
        saved = n_out;
        repeat (60) @(negedge clk);
        check_val("midrst_no_valid", n_out, saved);
        check_val("midrst_no_done", n_done, 0);
        check_val("midrst_idle", busy, 0);
        apply_stimulus(1'b0);
        wait_done();
        check_output("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
